// File: rtl/hs_npu_layer_sequencer.sv
// hs_npu_layer_sequencer: CPU-facing layer descriptor queue that issues one
// layer at a time to the NPU layer-control interface. It watches the
// exec_valid/exec_ready handshake for completion, counts finished layers, and
// halts on hangs or descriptors with a zero dimension.
module hs_npu_layer_sequencer #(
    parameter int WORD_WIDTH     = 32,
    parameter int QUEUE_DEPTH    = 4,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int BUSY_WAIT_MAX  = 4,
    parameter int COUNT_WIDTH    = 16,
    parameter int DESC_W         = 7*WORD_WIDTH+6
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [DESC_W-1:0]                  cmd_desc_i,
    input  logic                               cmd_valid_i,
    output logic                               cmd_ready_o,
    input  logic                               flush_i,
    input  logic                               clear_error_i,
    output logic                               exec_valid_o,
    input  logic                               exec_ready_i,
    output logic [DESC_W-1:0]                  desc_o,
    output logic                               busy_o,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]   level_o,
    output logic                               done_pulse_o,
    output logic [COUNT_WIDTH-1:0]             layers_done_o,
    output logic                               error_o,
    output logic [1:0]                         error_code_o
);
    localparam int LVL_W = $clog2(QUEUE_DEPTH+1);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES+1);
    localparam int BW_W  = $clog2(BUSY_WAIT_MAX+1);

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_ZERO    = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_HALT      = 3'd4
    } state_t;

    // The first error code stays visible until software clears it.
    function automatic logic [1:0] first_code(input logic err, input logic [1:0] cur,
                                              input logic [1:0] new_code);
        return err ? cur : new_code;
    endfunction

    logic [DESC_W-1:0]      mem_q [QUEUE_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]       level_q, level_d;
    logic                   cmd_ready_q;
    state_t                 state_q;
    logic [DESC_W-1:0]      desc_q;
    logic                   exec_valid_q, busy_q, done_pulse_q, error_q;
    logic [1:0]             error_code_q;
    logic [COUNT_WIDTH-1:0] layers_done_q;
    logic [TMR_W-1:0]       timer_q;
    logic [BW_W-1:0]        busy_cnt_q;

    logic                   push_s, pop_s, zero_dim_s, timeout_s;
    logic [DESC_W-1:0]      head_s;

    // Queue handshake decode, next level and head-descriptor checks.
    always_comb begin
        push_s     = cmd_valid_i && cmd_ready_q && !flush_i;
        pop_s      = (state_q == ST_IDLE) && (level_q != '0) && !error_q;
        head_s     = mem_q[rd_ptr_q];
        zero_dim_s = (head_s[WORD_WIDTH-1:0] == '0) ||
                     (head_s[2*WORD_WIDTH-1:WORD_WIDTH] == '0) ||
                     (head_s[3*WORD_WIDTH-1:2*WORD_WIDTH] == '0) ||
                     (head_s[4*WORD_WIDTH-1:3*WORD_WIDTH] == '0);
        timeout_s  = (timer_q == TMR_W'(TIMEOUT_CYCLES-1));
        if (push_s && !pop_s) begin
            level_d = level_q + LVL_W'(1);
        end else if (!push_s && pop_s) begin
            level_d = level_q - LVL_W'(1);
        end else begin
            level_d = level_q;
        end
    end

    // Descriptor storage; slots need no reset because the pointers gate reads.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= cmd_desc_i;
        end
    end

    // Queue pointers, occupancy and registered ready; flush empties the queue
    // but leaves any layer already popped to run to completion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            cmd_ready_q <= 1'b1;
        end else if (flush_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            cmd_ready_q <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            level_q     <= level_d;
            cmd_ready_q <= (level_d < LVL_W'(QUEUE_DEPTH));
        end
    end

    // Layer issue FSM: pop, handshake, wait for busy, wait for idle, halt on error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            desc_q        <= '0;
            exec_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_pulse_q  <= 1'b0;
            layers_done_q <= '0;
            error_q       <= 1'b0;
            error_code_q  <= ERR_NONE;
            timer_q       <= '0;
            busy_cnt_q    <= '0;
        end else begin
            done_pulse_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pop_s && zero_dim_s) begin
                        state_q      <= ST_HALT;
                        busy_q       <= 1'b1;
                        error_q      <= 1'b1;
                        error_code_q <= first_code(error_q, error_code_q, ERR_ZERO);
                    end else if (pop_s) begin
                        state_q      <= ST_ISSUE;
                        desc_q       <= head_s;
                        exec_valid_q <= 1'b1;
                        busy_q       <= 1'b1;
                        timer_q      <= '0;
                    end else begin
                        busy_q       <= 1'b0;
                    end
                end
                ST_ISSUE, ST_WAIT_BUSY, ST_WAIT_DONE: begin
                    timer_q <= timer_q + TMR_W'(1);
                    if (timeout_s) begin
                        state_q      <= ST_HALT;
                        exec_valid_q <= 1'b0;
                        error_q      <= 1'b1;
                        error_code_q <= first_code(error_q, error_code_q, ERR_TIMEOUT);
                    end else if (state_q == ST_ISSUE) begin
                        if (exec_ready_i) begin
                            state_q      <= ST_WAIT_BUSY;
                            exec_valid_q <= 1'b0;
                            busy_cnt_q   <= '0;
                        end else begin
                            state_q      <= ST_ISSUE;
                        end
                    end else if (state_q == ST_WAIT_BUSY && !exec_ready_i) begin
                        state_q <= ST_WAIT_DONE;
                    end else if (state_q == ST_WAIT_BUSY &&
                                 busy_cnt_q != BW_W'(BUSY_WAIT_MAX-1)) begin
                        busy_cnt_q <= busy_cnt_q + BW_W'(1);
                    end else if (exec_ready_i) begin
                        // NPU is idle again (or never went busy): layer done.
                        state_q       <= ST_IDLE;
                        busy_q        <= 1'b0;
                        done_pulse_q  <= 1'b1;
                        layers_done_q <= layers_done_q + COUNT_WIDTH'(1);
                    end else begin
                        state_q <= state_q;
                    end
                end
                ST_HALT: begin
                    if (clear_error_i) begin
                        state_q      <= ST_IDLE;
                        busy_q       <= 1'b0;
                        error_q      <= 1'b0;
                        error_code_q <= ERR_NONE;
                    end else begin
                        state_q      <= ST_HALT;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    exec_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready_o   = cmd_ready_q;
    assign level_o       = level_q;
    assign exec_valid_o  = exec_valid_q;
    assign desc_o        = desc_q;
    assign busy_o        = busy_q;
    assign done_pulse_o  = done_pulse_q;
    assign layers_done_o = layers_done_q;
    assign error_o       = error_q;
    assign error_code_o  = error_code_q;
endmodule

// File: tb/tb_hs_npu_layer_sequencer.sv
// Directed bench for hs_npu_layer_sequencer. A short timeout and a narrow
// layer counter keep the timeout and counter-wrap cases within a few hundred
// cycles.
module tb_hs_npu_layer_sequencer;
    localparam int WW  = 32;
    localparam int QD  = 4;
    localparam int TO  = 64;
    localparam int BWM = 4;
    localparam int CW  = 4;
    localparam int DW  = 7*WW+6;
    localparam int LW  = $clog2(QD+1);

    logic          clk = 1'b0;
    logic          rst_n, cmd_valid_i, cmd_ready_o, flush_i, clear_error_i;
    logic          exec_valid_o, exec_ready_i, busy_o, done_pulse_o, error_o;
    logic [DW-1:0] cmd_desc_i, desc_o;
    logic [LW-1:0] level_o;
    logic [CW-1:0] layers_done_o;
    logic [1:0]    error_code_o;

    int n_run  = 0;
    int n_fail = 0;
    int done_cnt = 0;
    logic [DW-1:0] issued_q [$];
    logic [DW-1:0] exp_q [$];

    hs_npu_layer_sequencer #(
        .WORD_WIDTH(WW), .QUEUE_DEPTH(QD), .TIMEOUT_CYCLES(TO),
        .BUSY_WAIT_MAX(BWM), .COUNT_WIDTH(CW), .DESC_W(DW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd_desc_i(cmd_desc_i), .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o), .flush_i(flush_i), .clear_error_i(clear_error_i),
        .exec_valid_o(exec_valid_o), .exec_ready_i(exec_ready_i), .desc_o(desc_o),
        .busy_o(busy_o), .level_o(level_o), .done_pulse_o(done_pulse_o),
        .layers_done_o(layers_done_o), .error_o(error_o), .error_code_o(error_code_o)
    );

    always #5 clk = ~clk;

    // Record handshaken descriptors and completion pulses mid-cycle.
    always @(negedge clk) begin
        if (exec_valid_o && exec_ready_i) issued_q.push_back(desc_o);
        if (done_pulse_o) done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] mk_desc(input logic [31:0] r, input logic [31:0] c,
                                              input logic [31:0] wr, input logic [31:0] wc,
                                              input logic [31:0] tag);
        logic [DW-1:0] d;
        d = '0;
        d[31:0]    = r;
        d[63:32]   = c;
        d[95:64]   = wr;
        d[127:96]  = wc;
        d[159:128] = tag & 32'h1F;
        d[191:160] = 32'h1000 + tag;
        d[223:192] = 32'h8000 + tag;
        d[229:224] = tag[5:0];
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 20 && !exec_valid_o; i++) tick();
        check(tag, exec_valid_o, 1);
    endtask

    // Accept the issued layer, stay busy for busy_len cycles, then go idle.
    task automatic serve_one(input int busy_len, input string tag);
        wait_valid({tag, "_valid"});
        exec_ready_i = 1'b1;
        tick();
        check({tag, "_valid_drop"}, exec_valid_o, 0);
        exec_ready_i = 1'b0;
        repeat (busy_len) tick();
        exec_ready_i = 1'b1;
        tick();
        check({tag, "_done"}, done_pulse_o, 1);
        exec_ready_i = 1'b0;
    endtask

    task automatic push(input logic [DW-1:0] d);
        cmd_desc_i  = d;
        cmd_valid_i = 1'b1;
        tick();
        cmd_valid_i = 1'b0;
    endtask

    logic [DW-1:0] d1, z, v, t;

    initial begin
        rst_n = 1'b0; cmd_valid_i = 1'b0; cmd_desc_i = '0; flush_i = 1'b0;
        clear_error_i = 1'b0; exec_ready_i = 1'b0;
        repeat (2) tick();
        check("rst_ready", cmd_ready_o, 1);
        check("rst_valid", exec_valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_level", level_o, 0);
        check("rst_layers", layers_done_o, 0);
        check("rst_err", {error_o, error_code_o}, 0);
        check("rst_desc", desc_o, 0);
        rst_n = 1'b1;
        tick();

        // Single layer: latency, stable descriptor, completion after busy period.
        d1 = mk_desc(32'd4, 32'd8, 32'd8, 32'd8, 32'd1);
        exec_ready_i = 1'b1;
        push(d1);
        check("t1_level", level_o, 1);
        check("t1_valid_early", exec_valid_o, 0);
        tick();
        check("t1_valid", exec_valid_o, 1);
        check("t1_desc", desc_o, d1);
        check("t1_busy", busy_o, 1);
        tick();
        check("t1_valid_drop", exec_valid_o, 0);
        exec_ready_i = 1'b0;
        repeat (20) tick();
        check("t1_no_done_yet", done_pulse_o, 0);
        check("t1_desc_hold", desc_o, d1);
        exec_ready_i = 1'b1;
        tick();
        check("t1_done", done_pulse_o, 1);
        check("t1_layers", layers_done_o, 1);
        exec_ready_i = 1'b0;
        tick();
        check("t1_pulse_one", done_pulse_o, 0);
        check("t1_idle", busy_o, 0);

        // Fill the queue behind a running layer, stall a push, drain in order.
        issued_q.delete();
        exp_q.delete();
        for (int i = 0; i < 6; i++) exp_q.push_back(mk_desc(32'd2 + i, 32'd3, 32'd4, 32'd5, 32'd16 + i));
        push(exp_q[0]);
        wait_valid("t2_first_valid");
        exec_ready_i = 1'b1;
        tick();
        exec_ready_i = 1'b0;
        tick();
        for (int i = 1; i < 5; i++) push(exp_q[i]);
        check("t2_full_level", level_o, 4);
        check("t2_full_ready", cmd_ready_o, 0);
        cmd_desc_i  = exp_q[5];
        cmd_valid_i = 1'b1;
        tick();
        check("t2_stall_level", level_o, 4);
        exec_ready_i = 1'b1;
        tick();
        check("t2_first_done", done_pulse_o, 1);
        exec_ready_i = 1'b0;
        for (int i = 0; i < 10 && !cmd_ready_o; i++) tick();
        check("t2_ready_back", cmd_ready_o, 1);
        tick();
        cmd_valid_i = 1'b0;
        check("t2_refill_level", level_o, 4);
        for (int i = 1; i < 6; i++) serve_one(3, "t2_layer");
        check("t2_issued_n", issued_q.size(), 6);
        for (int i = 0; i < 6 && i < issued_q.size(); i++)
            check($sformatf("t2_order%0d", i), issued_q[i], exp_q[i]);
        check("t2_layers", layers_done_o, 7);

        // Flush while a layer runs: queue empties, the running layer still finishes.
        issued_q.delete();
        cmd_valid_i = 1'b1;
        cmd_desc_i = mk_desc(32'd1, 32'd1, 32'd1, 32'd1, 32'd30); tick();
        cmd_desc_i = mk_desc(32'd1, 32'd1, 32'd1, 32'd2, 32'd31); tick();
        cmd_desc_i = mk_desc(32'd1, 32'd1, 32'd1, 32'd3, 32'd32); tick();
        cmd_valid_i = 1'b0;
        check("t3_level", level_o, 2);
        wait_valid("t3_valid");
        exec_ready_i = 1'b1;
        tick();
        exec_ready_i = 1'b0;
        tick();
        flush_i = 1'b1;
        cmd_valid_i = 1'b1;
        tick();
        flush_i = 1'b0;
        cmd_valid_i = 1'b0;
        check("t3_flush_level", level_o, 0);
        check("t3_flush_busy", busy_o, 1);
        repeat (4) tick();
        check("t3_level_stays", level_o, 0);
        exec_ready_i = 1'b1;
        tick();
        check("t3_done", done_pulse_o, 1);
        check("t3_layers", layers_done_o, 8);
        exec_ready_i = 1'b0;
        repeat (8) tick();
        check("t3_no_valid", exec_valid_o, 0);
        check("t3_idle", busy_o, 0);
        check("t3_issued_n", issued_q.size(), 1);

        // Zero dimension halts; the queued good descriptor waits for clear.
        issued_q.delete();
        z = mk_desc(32'd4, 32'd4, 32'd4, 32'd0, 32'd40);
        v = mk_desc(32'd6, 32'd7, 32'd7, 32'd9, 32'd41);
        push(z);
        push(v);
        check("t4_err", error_o, 1);
        check("t4_code", error_code_o, 2'b10);
        check("t4_valid", exec_valid_o, 0);
        check("t4_level", level_o, 1);
        repeat (5) tick();
        check("t4_held_valid", exec_valid_o, 0);
        check("t4_held_level", level_o, 1);
        clear_error_i = 1'b1;
        tick();
        clear_error_i = 1'b0;
        check("t4_cleared", {error_o, error_code_o}, 0);
        serve_one(2, "t4_layer");
        check("t4_issued_n", issued_q.size(), 1);
        if (issued_q.size() > 0) check("t4_issued", issued_q[0], v);
        check("t4_layers", layers_done_o, 9);

        // Timeout: NPU accepts and never returns to idle.
        t = mk_desc(32'd3, 32'd3, 32'd3, 32'd3, 32'd50);
        push(t);
        tick();
        check("t5_valid", exec_valid_o, 1);
        exec_ready_i = 1'b1;
        tick();
        exec_ready_i = 1'b0;
        repeat (62) tick();
        check("t5_err_before", error_o, 0);
        check("t5_busy_before", busy_o, 1);
        tick();
        check("t5_err", error_o, 1);
        check("t5_code", error_code_o, 2'b01);
        check("t5_valid_low", exec_valid_o, 0);
        check("t5_no_done", done_cnt, 9);
        check("t5_layers", layers_done_o, 9);
        clear_error_i = 1'b1;
        tick();
        clear_error_i = 1'b0;
        push(t);
        wait_valid("t5b_valid");
        exec_ready_i = 1'b1;
        tick();
        exec_ready_i = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        exec_ready_i = 1'b1;
        tick();
        check("t5_rst_valid", exec_valid_o, 0);
        check("t5_rst_busy", busy_o, 0);
        check("t5_rst_ready", cmd_ready_o, 1);
        check("t5_rst_level", level_o, 0);
        check("t5_rst_layers", layers_done_o, 0);
        check("t5_rst_err", {error_o, error_code_o}, 0);
        check("t5_rst_desc", desc_o, 0);
        rst_n = 1'b1;
        exec_ready_i = 1'b0;
        tick();
        check("t5_rst_no_done", done_cnt, 9);

        // NPU never drops ready: completion after the busy-wait window, then wrap.
        exec_ready_i = 1'b1;
        push(mk_desc(32'd1, 32'd2, 32'd3, 32'd4, 32'd60));
        tick();
        check("t6_valid", exec_valid_o, 1);
        tick();
        check("t6_valid_drop", exec_valid_o, 0);
        repeat (3) tick();
        check("t6_no_done_early", done_pulse_o, 0);
        check("t6_busy", busy_o, 1);
        tick();
        check("t6_done", done_pulse_o, 1);
        check("t6_layers", layers_done_o, 1);
        exec_ready_i = 1'b0;
        for (int i = 0; i < 14; i++) begin
            push(mk_desc(32'd1, 32'd1, 32'd2, 32'd2, 32'd61 + i));
            serve_one(1, "t6_fill");
        end
        check("t6_layers_max", layers_done_o, 15);
        exec_ready_i = 1'b1;
        push(mk_desc(32'd5, 32'd5, 32'd5, 32'd5, 32'd99));
        repeat (5) tick();
        check("t6_wrap_no_done", done_pulse_o, 0);
        tick();
        check("t6_wrap_done", done_pulse_o, 1);
        check("t6_wrap", layers_done_o, 0);
        exec_ready_i = 1'b0;
        tick();
        check("t6_total_done", done_cnt, 25);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
